// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//
// Registers the decode->execute bus, selects the ALU operands, computes the
// ALU result, drives the data-SRAM request and forwards the register-file
// write target back to decode. DIV/DIVU run on a radix-2 restoring divider
// that holds the pipeline through stallreq until quotient/remainder are ready.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-low reset
//   stall[5:0]      pipeline stall vector (bit 2 = this stage, bit 3 = memory)
//   stallreq        high while a divide is in progress
//   id_to_ex_bus    159-bit decode->execute bus
//   ex_to_mem_bus   76-bit execute->memory bus
//   ex_rf_we/ex_rf_waddr/ex_ex_result   forwarding path to decode
//   data_sram_en/wen/addr/wdata         data-SRAM request
//   hilo_we, hi_wdata (remainder), lo_wdata (quotient)
//   div_state       divider FSM state (debug observation)
//
// Stall handshake: stallreq is a combinational request that is high from the
// cycle a divide is first seen in EX until the last RUN cycle. The pipeline
// controller answers by holding stall[2] (and stall[3]) high, which freezes
// the input register so the divide operands stay stable. When stallreq drops
// the result is presented with hilo_we; the instruction leaves on the first
// cycle stall[2] is low.
module ex_stage #(
  parameter int DIV_ITERS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  output logic         stallreq,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic         ex_rf_we,
  output logic [4:0]   ex_rf_waddr,
  output logic [31:0]  ex_ex_result,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         hilo_we,
  output logic [31:0]  hi_wdata,
  output logic [31:0]  lo_wdata,
  output logic [1:0]   div_state
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int CW = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

  // ---------------------------------------------------------------- input register
  logic [158:0] bus_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_r <= '0;
    end else if (stall[2] && !stall[3]) begin
      bus_r <= '0;                       // bubble into memory stage
    end else if (!stall[2]) begin
      bus_r <= id_to_ex_bus;
    end
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_alu_src1;
  logic [3:0]  sel_alu_src2;
  logic        data_ram_en, rf_we, sel_rf_res;
  logic [3:0]  data_ram_wen;
  logic [4:0]  rf_waddr;

  assign pc           = bus_r[158:127];
  assign inst         = bus_r[126:95];
  assign alu_op       = bus_r[94:83];
  assign sel_alu_src1 = bus_r[82:80];
  assign sel_alu_src2 = bus_r[79:76];
  assign data_ram_en  = bus_r[75];
  assign data_ram_wen = bus_r[74:71];
  assign rf_we        = bus_r[70];
  assign rf_waddr     = bus_r[69:65];
  assign sel_rf_res   = bus_r[64];
  assign rdata1       = bus_r[63:32];
  assign rdata2       = bus_r[31:0];

  // ---------------------------------------------------------------- ALU
  logic [31:0] a_op, b_op, alu_res, sra_res;

  assign a_op = ({32{sel_alu_src1[0]}} & rdata1)
              | ({32{sel_alu_src1[1]}} & pc)
              | ({32{sel_alu_src1[2]}} & {27'b0, inst[10:6]});

  assign b_op = ({32{sel_alu_src2[0]}} & rdata2)
              | ({32{sel_alu_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_alu_src2[2]}} & 32'd8)
              | ({32{sel_alu_src2[3]}} & {16'b0, inst[15:0]});

  assign sra_res = 32'($signed(b_op) >>> a_op[4:0]);

  assign alu_res = ({32{alu_op[11]}} & (a_op + b_op))
                 | ({32{alu_op[10]}} & (a_op - b_op))
                 | ({32{alu_op[9]}}  & {31'b0, $signed(a_op) < $signed(b_op)})
                 | ({32{alu_op[8]}}  & {31'b0, a_op < b_op})
                 | ({32{alu_op[7]}}  & (a_op & b_op))
                 | ({32{alu_op[6]}}  & ~(a_op | b_op))
                 | ({32{alu_op[5]}}  & (a_op | b_op))
                 | ({32{alu_op[4]}}  & (a_op ^ b_op))
                 | ({32{alu_op[3]}}  & (b_op << a_op[4:0]))
                 | ({32{alu_op[2]}}  & (b_op >> a_op[4:0]))
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & {b_op[15:0], 16'b0});

  // ---------------------------------------------------------------- outputs
  assign ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, alu_res};
  assign ex_rf_we        = rf_we;
  assign ex_rf_waddr     = rf_waddr;
  assign ex_ex_result    = alu_res;
  assign data_sram_en    = data_ram_en;
  assign data_sram_wen   = data_ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = rdata2;

  // ---------------------------------------------------------------- divider
  // funct 0x1A = DIV, 0x1B = DIVU; they differ only in bit 0.
  logic is_div, is_signed_div;
  assign is_div        = (inst[31:26] == 6'b0) && (inst[5:1] == 5'b01101);
  assign is_signed_div = ~inst[0];

  div_state_t  state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0] quo, rem, dsor, dividend_raw;
  logic        neg_q, neg_r, div_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (is_div) begin
          stallreq   = 1'b1;
          state_next = DIV_RUN;
        end
      end
      DIV_RUN: begin
        stallreq = 1'b1;
        if (cnt == LAST_ITER) state_next = DIV_DONE;
      end
      DIV_DONE: begin
        // Leave only when the instruction itself leaves, so it never restarts.
        if (!stall[2]) state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  logic [32:0] shifted, diff;
  logic        fits;
  logic [31:0] rem_step, quo_step;

  assign shifted  = {rem, quo[31]};
  assign diff     = shifted - {1'b0, dsor};
  assign fits     = shifted >= {1'b0, dsor};
  assign rem_step = fits ? diff[31:0] : shifted[31:0];
  assign quo_step = {quo[30:0], fits};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      quo          <= '0;
      rem          <= '0;
      dsor         <= '0;
      dividend_raw <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (is_div) begin
            cnt          <= '0;
            rem          <= '0;
            quo          <= (is_signed_div && rdata1[31]) ? (32'd0 - rdata1) : rdata1;
            dsor         <= (is_signed_div && rdata2[31]) ? (32'd0 - rdata2) : rdata2;
            dividend_raw <= rdata1;
            neg_q        <= is_signed_div && (rdata1[31] ^ rdata2[31]);
            neg_r        <= is_signed_div && rdata1[31];
            div_zero     <= (rdata2 == 32'd0);
          end
        end
        DIV_RUN: begin
          cnt <= cnt + 1'b1;
          quo <= quo_step;
          rem <= rem_step;
        end
        default: ;
      endcase
    end
  end

  logic        done;
  logic [31:0] q_fix, r_fix;

  assign done     = (state == DIV_DONE);
  assign q_fix    = neg_q ? (32'd0 - quo) : quo;
  assign r_fix    = neg_r ? (32'd0 - rem) : rem;
  assign hilo_we  = done;
  // Divide by zero returns all-ones and the dividend untouched, signed or not.
  assign lo_wdata = !done ? 32'd0 : (div_zero ? 32'hFFFF_FFFF : q_fix);
  assign hi_wdata = !done ? 32'd0 : (div_zero ? dividend_raw : r_fix);
  assign div_state = state;

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], diff[32]};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. Table vectors for the ALU,
// random ALU traffic against a behavioural model, and hand-written divide,
// stall and reset sequences.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         stallreq;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic         ex_rf_we;
  logic [4:0]   ex_rf_waddr;
  logic [31:0]  ex_ex_result;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         hilo_we;
  logic [31:0]  hi_wdata;
  logic [31:0]  lo_wdata;
  logic [1:0]   div_state;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .stallreq(stallreq),
    .id_to_ex_bus(id_to_ex_bus), .ex_to_mem_bus(ex_to_mem_bus),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_ex_result(ex_ex_result),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .div_state(div_state)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] side_view();
    return 128'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                 ex_rf_we, ex_rf_waddr, ex_ex_result, stallreq, hilo_we});
  endfunction

  function automatic logic [158:0] make_bus(
      input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic dre,
      input logic [3:0] dwen, input logic rfwe, input logic [4:0] waddr,
      input logic selres, input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, dre, dwen, rfwe, waddr, selres, r1, r2};
  endfunction

  // ---------------------------------------------------------------- reference model
  function automatic logic [31:0] ref_alu(
      input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] r1,
      input logic [31:0] r2, input logic [11:0] op, input logic [2:0] s1,
      input logic [3:0] s2);
    logic [31:0] a, b, res, imm_s, imm_z;
    int sh;
    imm_z = 32'(inst[15:0]);
    imm_s = inst[15] ? (imm_z | 32'hFFFF_0000) : imm_z;
    a = 0; b = 0; res = 0;
    if (s1[0]) a |= r1;
    if (s1[1]) a |= pc;
    if (s1[2]) a |= 32'(inst[10:6]);
    if (s2[0]) b |= r2;
    if (s2[1]) b |= imm_s;
    if (s2[2]) b |= 32'd8;
    if (s2[3]) b |= imm_z;
    sh = int'(a % 32);
    if (op[11]) res |= a + b;
    if (op[10]) res |= a - b;
    if (op[9])  res |= (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    if (op[8])  res |= (a < b) ? 32'd1 : 32'd0;
    if (op[7])  res |= a & b;
    if (op[6])  res |= ~(a | b);
    if (op[5])  res |= a | b;
    if (op[4])  res |= a ^ b;
    if (op[3])  res |= b << sh;
    if (op[2])  res |= b >> sh;
    if (op[1])  res |= 32'(int'(b) >>> sh);
    if (op[0])  res |= b * 32'd65536;
    return res;
  endfunction

  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
    longint la, lb, q, r;
    la = sgn ? longint'(int'(a)) : longint'(a);
    lb = sgn ? longint'(int'(b)) : longint'(b);
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else begin
      q = la / lb;
      r = la % lb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic alu_case(input string name, input logic [31:0] pc, input logic [31:0] inst,
      input logic [31:0] r1, input logic [31:0] r2, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic dre, input logic [3:0] dwen,
      input logic rfwe, input logic [4:0] waddr, input logic selres, input logic [31:0] exp_res);
    logic [127:0] e_bus, e_side;
    @(negedge clk);
    stall = 6'b0;
    id_to_ex_bus = make_bus(pc, inst, op, s1, s2, dre, dwen, rfwe, waddr, selres, r1, r2);
    exp_q.push_back(128'({pc, dre, dwen, selres, rfwe, waddr, exp_res}));
    exp_q.push_back(128'({dre, dwen, exp_res, r2, rfwe, waddr, exp_res, 1'b0, 1'b0}));
    @(posedge clk);
    @(negedge clk);
    e_bus  = exp_q.pop_front();
    e_side = exp_q.pop_front();
    check({name, "_bus"}, 128'(ex_to_mem_bus), e_bus);
    check({name, "_side"}, side_view(), e_side);
  endtask

  task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int cycles;
    logic [31:0] inst;
    inst = {6'b0, 5'd4, 5'd5, 10'b0, sgn ? 6'h1A : 6'h1B};
    @(negedge clk);
    stall = 6'b0;
    id_to_ex_bus = make_bus(32'hBFC0_0100, inst, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, a, b);
    @(posedge clk);
    cycles = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stallreq) break;
      cycles++;
      stall = 6'b001111;
      id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
    end
    check({name, "_stall_cycles"}, 128'(cycles), 128'd33);
    check({name, "_done"}, 128'({hilo_we, lo_wdata, hi_wdata}), 128'({1'b1, exp_lo, exp_hi}));
    // Downstream stall keeps the instruction (and its result) in DONE.
    stall = 6'b001111;
    @(posedge clk);
    @(negedge clk);
    check({name, "_hold"}, 128'({stallreq, hilo_we, lo_wdata, hi_wdata}),
          128'({1'b0, 1'b1, exp_lo, exp_hi}));
    stall = 6'b0;
    id_to_ex_bus = '0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_leave"}, 128'({stallreq, hilo_we}), 128'd0);
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic [31:0] pc, inst, r1, r2;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] pc, inst, r1, r2, e, lo, hi;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  dwen;
    logic [4:0]  waddr;
    logic        dre, rfwe, selres, sgn;
    int          k, hilo_seen;

    vecs[0]  = '{32'hBFC0_0000, 32'h3422_00FF, 32'h0000_F000, 32'h0, 12'h020, 3'b001, 4'b1000, 32'h0000_F0FF}; // ori
    vecs[1]  = '{32'hBFC0_0004, 32'h2422_FFFF, 32'd5,         32'h0, 12'h800, 3'b001, 4'b0010, 32'd4};        // addiu
    vecs[2]  = '{32'hBFC0_0008, 32'h3C02_1234, 32'h0,         32'h0, 12'h001, 3'b000, 4'b1000, 32'h1234_0000}; // lui
    vecs[3]  = '{32'hBFC0_000C, 32'h0043_1023, 32'd3,         32'd5, 12'h400, 3'b001, 4'b0001, 32'hFFFF_FFFE}; // subu
    vecs[4]  = '{32'hBFC0_0010, 32'h0043_102A, 32'hFFFF_FFFF, 32'd1, 12'h200, 3'b001, 4'b0001, 32'd1};        // slt
    vecs[5]  = '{32'hBFC0_0014, 32'h0043_102B, 32'hFFFF_FFFF, 32'd1, 12'h100, 3'b001, 4'b0001, 32'd0};        // sltu
    vecs[6]  = '{32'hBFC0_0018, 32'h0043_1024, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h080, 3'b001, 4'b0001, 32'hF000_F000};
    vecs[7]  = '{32'hBFC0_001C, 32'h0043_1027, 32'h0F0F_0000, 32'h0000_0F0F, 12'h040, 3'b001, 4'b0001, 32'hF0F0_F0F0};
    vecs[8]  = '{32'hBFC0_0020, 32'h0043_1026, 32'hAAAA_5555, 32'hFFFF_0000, 12'h010, 3'b001, 4'b0001, 32'h5555_5555};
    vecs[9]  = '{32'hBFC0_0024, 32'h0000_0100, 32'h0,         32'h0000_000F, 12'h008, 3'b100, 4'b0001, 32'h0000_00F0}; // sll 4
    vecs[10] = '{32'hBFC0_0028, 32'h0000_0102, 32'h0,         32'h8000_0000, 12'h004, 3'b100, 4'b0001, 32'h0800_0000}; // srl 4
    vecs[11] = '{32'hBFC0_002C, 32'h0000_0103, 32'h0,         32'h8000_0000, 12'h002, 3'b100, 4'b0001, 32'hF800_0000}; // sra 4
    vecs[12] = '{32'hBFC0_0030, 32'h0C00_0000, 32'h0,         32'h0, 12'h800, 3'b010, 4'b0100, 32'hBFC0_0038};      // jal link
    vecs[13] = '{32'hBFC0_0034, 32'h2422_1111, 32'd9,         32'd9, 12'h000, 3'b001, 4'b0001, 32'd0};              // no op
    vecs[14] = '{32'hBFC0_0038, 32'h2422_0000, 32'h1234,      32'd7, 12'h800, 3'b000, 4'b0001, 32'd7};              // A = 0
    vecs[15] = '{32'hBFC0_003C, 32'h2422_0000, 32'd1,         32'h10, 12'h800, 3'b001, 4'b0101, 32'h19};           // B and-or

    // ---- reset
    rst = 1'b0;
    stall = 6'b0;
    id_to_ex_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          128'({ex_to_mem_bus, stallreq, hilo_we, hi_wdata[15:0]}) | side_view() | 128'({lo_wdata, hi_wdata}),
          128'd0);
    rst = 1'b1;

    // ---- table vectors
    for (int i = 0; i < 16; i++) begin
      alu_case($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].r1, vecs[i].r2,
               vecs[i].op, vecs[i].s1, vecs[i].s2, 1'b0, 4'b0, 1'b1, 5'(i + 1), 1'b0, vecs[i].exp);
    end

    // ---- stall: bubble, then hold
    alu_case("stall_pre", vecs[0].pc, vecs[0].inst, vecs[0].r1, vecs[0].r2, vecs[0].op,
             vecs[0].s1, vecs[0].s2, 1'b1, 4'hF, 1'b1, 5'd3, 1'b1, vecs[0].exp);
    @(negedge clk);
    stall = 6'b000100;
    id_to_ex_bus = make_bus(32'h1, 32'h2422_0001, 12'h800, 3'b1, 4'b1, 1'b1, 4'hF, 1'b1, 5'd9, 1'b0, 32'd1, 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("stall_bubble", 128'(ex_to_mem_bus), 128'd0);
    alu_case("stall_reload", vecs[1].pc, vecs[1].inst, vecs[1].r1, vecs[1].r2, vecs[1].op,
             vecs[1].s1, vecs[1].s2, 1'b0, 4'b0, 1'b1, 5'd4, 1'b0, vecs[1].exp);
    @(negedge clk);
    stall = 6'b001100;
    id_to_ex_bus = make_bus(32'h1, 32'h2422_0001, 12'h800, 3'b1, 4'b1, 1'b1, 4'hF, 1'b1, 5'd9, 1'b0, 32'd1, 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("stall_hold", 128'(ex_to_mem_bus),
          128'({vecs[1].pc, 1'b0, 4'b0, 1'b0, 1'b1, 5'd4, vecs[1].exp}));
    stall = 6'b0;

    // ---- random ALU traffic vs model
    for (int i = 0; i < 150; i++) begin
      pc = $urandom; inst = $urandom; r1 = $urandom; r2 = $urandom;
      if (inst[31:26] == 6'b0 && (inst[5:0] == 6'h1A || inst[5:0] == 6'h1B)) inst[5] = 1'b1;
      k = $urandom_range(0, 12);
      op = (k == 12) ? 12'b0 : (12'b1 << k);
      s1 = 3'($urandom_range(0, 7));
      s2 = 4'($urandom_range(0, 15));
      dre = 1'($urandom); dwen = 4'($urandom); rfwe = 1'($urandom);
      waddr = 5'($urandom); selres = 1'($urandom);
      e = ref_alu(pc, inst, r1, r2, op, s1, s2);
      alu_case($sformatf("rand%0d", i), pc, inst, r1, r2, op, s1, s2, dre, dwen, rfwe, waddr, selres, e);
    end

    // ---- divides
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    do_div("divu_9_0", 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
    do_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7);
    for (int i = 0; i < 6; i++) begin
      sgn = 1'($urandom);
      r1 = $urandom;
      r2 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (($urandom_range(0, 1) == 0) && r2[31]) r2 = -r2;
      ref_div(sgn, r1, r2, lo, hi);
      do_div($sformatf("div_rand%0d", i), sgn, r1, r2, lo, hi);
    end

    // ---- reset during RUN
    @(negedge clk);
    stall = 6'b0;
    id_to_ex_bus = make_bus(32'hBFC0_0200, {6'b0, 5'd4, 5'd5, 10'b0, 6'h1B}, 12'b0, 3'b0, 4'b0,
                            1'b1, 4'hF, 1'b1, 5'd7, 1'b1, 32'd100, 32'd7);
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      stall = 6'b001111;
      @(posedge clk);
    end
    @(negedge clk);
    id_to_ex_bus = '0;
    stall = 6'b0;
    rst = 1'b0;
    #1;
    check("rst_mid_run_ctl", 128'({stallreq, hilo_we, lo_wdata, hi_wdata}), 128'd0);
    check("rst_mid_run_bus", 128'(ex_to_mem_bus) | side_view(), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    hilo_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hilo_we || stallreq) hilo_seen++;
    end
    check("rst_no_hilo_after", 128'(hilo_seen), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits between the decode stage and the memory stage.
- Registers `id_to_ex_bus`, selects ALU operands, and computes the ALU result.
- Drives the data-SRAM request, and forwards its write target back to decode.
- Contains a 32-iteration radix-2 divider for DIV/DIVU. It holds the pipeline through `stallreq` until the quotient and remainder are ready.

Parameters:
- `DIV_ITERS`, default 32: number of RUN cycles in the divider (one quotient bit per cycle).

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, asynchronous and active-low.
- `stall`  in  6  pipeline stall vector. Bit 2 is this stage; bit 3 is the memory stage.
- `stallreq`  out  1  stall request; high while a divide is in progress.
- `id_to_ex_bus`  in  159  field layout:
  - [158:127] pc, [126:95] inst, [94:83] alu_op, [82:80] sel_alu_src1, [79:76] sel_alu_src2
  - [75] data_ram_en, [74:71] data_ram_wen, [70] rf_we, [69:65] rf_waddr, [64] sel_rf_res
  - [63:32] rdata1, [31:0] rdata2
- `ex_to_mem_bus`  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- `ex_rf_we`, `ex_rf_waddr`(5), `ex_ex_result`(32)  out  forwarding path to decode.
- `data_sram_en`  out  1; `data_sram_wen`  out  4; `data_sram_addr`  out  32; `data_sram_wdata`  out  32.
- `hilo_we`  out  1; `hi_wdata`  out  32 (remainder); `lo_wdata`  out  32 (quotient).

Behaviour:
- **Input register**, evaluated each clock edge in this priority order:
  - `rst` low: cleared asynchronously to 0.
  - `stall[2]`=1 and `stall[3]`=0: loads 0 (bubble).
  - `stall[2]`=0: loads `id_to_ex_bus`.
  - Otherwise: holds.
- **Operand A**:
  - `src1[0]` selects rdata1, `src1[1]` selects pc, `src1[2]` selects {27'b0, inst[10:6]}.
  - The selected terms are AND-OR combined; if no bit is set, A = 0.
- **Operand B**:
  - `src2[0]` selects rdata2.
  - `src2[1]` selects sign-extended inst[15:0].
  - `src2[2]` selects 32'd8.
  - `src2[3]` selects zero-extended inst[15:0].
  - The selected terms are AND-OR combined.
- **alu_op**: one-hot, bit 11 down to bit 0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add/sub: modulo 2^32.
  - slt: signed compare; sltu: unsigned compare.
  - Shifts: shift B by A[4:0].
  - lui: {B[15:0], 16'b0}.
  - All bits zero: result 0.
- **Combinational outputs**:
  - `ex_result` = ALU result; all bus fields pass through from the input register.
  - `data_sram_en` = data_ram_en; `data_sram_wen` = data_ram_wen.
  - `data_sram_addr` = ALU result; `data_sram_wdata` = rdata2.
  - `ex_rf_we` = rf_we; `ex_rf_waddr` = rf_waddr; `ex_ex_result` = ex_result.
- **Divide detect**:
  - inst[31:26]=0 with inst[5:0]=0x1A is DIV (signed).
  - inst[31:26]=0 with inst[5:0]=0x1B is DIVU.
  - Dividend is rdata1, divisor is rdata2.
- **Divider FSM**, states IDLE, RUN, DONE:
  - IDLE: on a divide detect, latch the operand magnitudes and signs, clear the counter, go to RUN. `stallreq`=1 combinationally in this same cycle.
  - RUN: one shift-subtract step per cycle. After `DIV_ITERS` cycles go to DONE. `stallreq`=1 throughout.
  - DONE: `stallreq`=0, `hilo_we`=1, `hi_wdata`/`lo_wdata` valid. Return to IDLE when `stall[2]`=0 (the instruction leaves). Stay in DONE otherwise, with `hilo_we` held. Never restart the same instruction.
  - Total residency of a divide in EX is 34 cycles (IDLE detect + 32 RUN + DONE).
- **Signed fixup**:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- **Divide by zero**: lo = 0xFFFFFFFF, hi = dividend as given; no trap; same 34-cycle timing.
- **Reset values**:
  - Input register 0, FSM IDLE, counter 0.
  - Hence every output is 0, including `stallreq` and `hilo_we`.
  - Reset asserted mid-RUN aborts the divide immediately; no `hilo_we` pulse follows.
- **Stalls during a divide**: `stall[2]` stays asserted (driven by `stallreq`), so the input register holds and operands stay stable.
- **Non-divide instructions**: zero-cycle latency; never assert `stallreq`.

Test Plan:
- ori with rdata1=0x0000F000, inst[15:0]=0x00FF, alu_op=or, src1[0], src2[3] -> `ex_ex_result`=0x0000F0FF and `ex_rf_we`=1 one cycle after load.
- addiu with rdata1=5, imm=0xFFFF (add, src2[1]) -> 4; lui with imm=0x1234 -> 0x12340000; subu 3-5 -> 0xFFFFFFFE.
- `stall[2]`=1, `stall[3]`=0 for one cycle -> next `ex_to_mem_bus`=0; `stall[2]`=`stall[3]`=1 -> register holds the previous value.
- DIVU 100/7 -> `stallreq` high for 33 cycles, then DONE with lo=14, hi=2, `hilo_we`=1; returns to IDLE once `stall[2]`=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 9/0 -> lo=0xFFFFFFFF, hi=9.
- `rst` low at RUN cycle 10 -> FSM IDLE, `stallreq`=0, all outputs 0 immediately; no `hilo_we` after `rst` deasserts.
